// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM states, line levels and default ROM contents for the serializer
package serial_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic TX_IDLE = 1'b1;
    localparam logic TX_START = 1'b0;
    // 16 bits covers the widest word; callers truncate to WORD_W, giving mod 2^WORD_W
    function automatic logic [15:0] table_word(input int depth, input int idx);
        return 16'(depth - 1 - idx);
    endfunction
endpackage

// File: rtl/rom_table.sv
// rom_table: combinational constant table, word[i] = (DEPTH-1-i) mod 2^WORD_W
module rom_table
    import serial_pkg::*;
#(
    parameter int WORD_W = 4,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input logic [AW-1:0] addr,
    output logic [WORD_W-1:0] word
);
    always_comb word = WORD_W'(table_word(DEPTH, int'(addr)));
endmodule

// File: rtl/rom_serializer.sv
// rom_serializer: walks the ROM table and frames each word (start, data, parity, stop) onto TX
module rom_serializer
    import serial_pkg::*;
#(
    parameter int WORD_W = 4,
    parameter int DEPTH = 16,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 0,
    parameter int LOOP = 1,
    localparam int AW = $clog2(DEPTH),
    localparam int BW = $clog2(WORD_W)
) (
    input logic hit,
    input logic clr,
    input logic start,
    input logic halt,
    input logic tick,
    output logic [AW-1:0] NOM,
    output logic [BW-1:0] BIT,
    output logic [WORD_W-1:0] LE,
    output logic TX,
    output logic busy,
    output logic done
);
    state_t state, state_n;
    logic [AW-1:0] nom_n;
    logic [BW-1:0] bit_n;
    logic tx_n, busy_n, done_n, pending, pending_n, halt_req, halt_req_n;
    logic last_word, last_bit;
    rom_table #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_rom (.addr(NOM), .word(LE));
    function automatic logic data_bit(input logic [WORD_W-1:0] w, input logic [BW-1:0] b);
        return (MSB_FIRST != 0) ? w[WORD_W-1-int'(b)] : w[b];
    endfunction
    assign last_word = NOM == AW'(DEPTH - 1);
    assign last_bit = BIT == BW'(WORD_W - 1);
    always_comb begin
        state_n = state;
        nom_n = NOM;
        bit_n = BIT;
        tx_n = TX;
        busy_n = busy;
        done_n = 1'b0;
        pending_n = (state == IDLE) ? (pending ? !tick : start) : pending;
        halt_req_n = halt_req | (busy & halt);
        if (tick) begin
            case (state)
                IDLE: if (pending) begin
                    state_n = START;
                    busy_n = 1'b1;
                    tx_n = TX_START;
                end
                START: begin
                    state_n = DATA;
                    bit_n = '0;
                    tx_n = data_bit(LE, '0);
                end
                DATA: if (last_bit) begin
                    state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    bit_n = '0;
                    tx_n = (PARITY_EN != 0) ? ^LE : TX_IDLE;
                end else begin
                    bit_n = BIT + 1'b1;
                    tx_n = data_bit(LE, BIT + 1'b1);
                end
                PARITY: begin
                    state_n = STOP;
                    tx_n = TX_IDLE;
                end
                STOP: begin
                    nom_n = last_word ? '0 : NOM + 1'b1;
                    done_n = last_word;
                    // a halt requested on this very edge carries into the next word
                    if (halt_req || (last_word && LOOP == 0)) begin
                        state_n = IDLE;
                        busy_n = 1'b0;
                        tx_n = TX_IDLE;
                        halt_req_n = 1'b0;
                    end else begin
                        state_n = START;
                        tx_n = TX_START;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge hit or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            NOM <= '0;
            BIT <= '0;
            TX <= TX_IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            pending <= 1'b0;
            halt_req <= 1'b0;
        end else begin
            state <= state_n;
            NOM <= nom_n;
            BIT <= bit_n;
            TX <= tx_n;
            busy <= busy_n;
            done <= done_n;
            pending <= pending_n;
            halt_req <= halt_req_n;
        end
    end
endmodule

// File: tb/tb_rom_serializer.sv
// tb_rom_serializer: scoreboard bench over four parameter sets sharing one clock and stimulus
module tb_rom_serializer;
    logic hit = 1'b0, clr = 1'b1, start = 1'b0, halt = 1'b0, tick = 1'b0;
    logic tx0, tx1, tx2, tx3, busy0, busy1, busy2, busy3, done0, done1, done2, done3;
    logic [3:0] nom0, nom1, nom2, le0, le1, le2;
    logic [2:0] nom3, le3;
    logic [1:0] bit0, bit1, bit2, bit3;
    int checks = 0, errors = 0, cur = 0, done_cnt = 0;
    logic last_exp = 1'b1;
    logic exp_q[$];
    int ww[4] = '{4, 4, 4, 3};
    int dd[4] = '{16, 16, 16, 5};
    int msb[4] = '{1, 0, 1, 1};
    int par[4] = '{0, 1, 0, 0};

    rom_serializer u0 (.hit(hit), .clr(clr), .start(start), .halt(halt), .tick(tick),
        .NOM(nom0), .BIT(bit0), .LE(le0), .TX(tx0), .busy(busy0), .done(done0));
    rom_serializer #(.MSB_FIRST(0), .PARITY_EN(1)) u1 (.hit(hit), .clr(clr), .start(start),
        .halt(halt), .tick(tick), .NOM(nom1), .BIT(bit1), .LE(le1), .TX(tx1), .busy(busy1), .done(done1));
    rom_serializer #(.LOOP(0)) u2 (.hit(hit), .clr(clr), .start(start), .halt(halt), .tick(tick),
        .NOM(nom2), .BIT(bit2), .LE(le2), .TX(tx2), .busy(busy2), .done(done2));
    rom_serializer #(.WORD_W(3), .DEPTH(5)) u3 (.hit(hit), .clr(clr), .start(start), .halt(halt),
        .tick(tick), .NOM(nom3), .BIT(bit3), .LE(le3), .TX(tx3), .busy(busy3), .done(done3));

    always #5 hit = ~hit;

    function automatic logic tx_of(input int i);
        return i == 0 ? tx0 : i == 1 ? tx1 : i == 2 ? tx2 : tx3;
    endfunction

    function automatic logic done_of(input int i);
        return i == 0 ? done0 : i == 1 ? done1 : i == 2 ? done2 : done3;
    endfunction

    always @(negedge hit) if (!clr && done_of(cur)) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input int inst, input int idx);
        int w;
        logic [31:0] v;
        w = ww[inst];
        v = 32'((dd[inst] - 1 - idx) & ((1 << w) - 1));
        exp_q.push_back(1'b0);
        for (int k = 0; k < w; k++) exp_q.push_back(v[msb[inst] != 0 ? w - 1 - k : k]);
        if (par[inst] != 0) exp_q.push_back(^v);
        exp_q.push_back(1'b1);
    endtask

    task automatic step(input logic t, input logic s, input logic h);
        tick = t;
        start = s;
        halt = h;
        @(posedge hit);
        #1;
        tick = 1'b0;
        start = 1'b0;
        halt = 1'b0;
        if (cur == 3) chk("bit_max", 32'(bit3 <= 2'd2), 1);
        if (t && exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            chk("tx", 32'(tx_of(cur)), 32'(last_exp));
        end else if (!t) chk("tx_hold", 32'(tx_of(cur)), 32'(last_exp));
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge hit);
        #1;
        clr = 1'b0;
        exp_q.delete();
        last_exp = 1'b1;
        done_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge hit);
        #1;
        chk("rst_tx0", 32'(tx0), 1);
        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_done0", 32'(done0), 0);
        chk("rst_nom0", 32'(nom0), 0);
        chk("rst_bit0", 32'(bit0), 0);
        chk("rst_le0", 32'(le0), 32'hF);
        chk("rst_le1", 32'(le1), 32'hF);
        chk("rst_le2", 32'(le2), 32'hF);
        chk("rst_le3", 32'(le3), 32'h4);
        chk("rst_txall", 32'({tx1, tx2, tx3}), 32'h7);
        chk("rst_busyall", 32'({busy1, busy2, busy3, done1, done2, done3}), 0);
        chk("rst_bitall", 32'({bit1, bit2, bit3}), 0);
        clr = 1'b0;
        // defaults: start coincides with a tick, so that tick only arms the run
        cur = 0;
        step(1, 1, 0);
        for (int i = 0; i < 6; i++) push_frame(0, i);
        exp_q.push_back(1'b1);
        for (int i = 1; i <= 37; i++) begin
            step(1, 0, 0);
            if (i == 1) chk("busy_on", 32'(busy0), 1);
            if (i == 6) chk("nom_hold", 32'(nom0), 0);
            if (i == 7) chk("nom_adv", 32'(nom0), 1);
            if (i == 33) begin
                chk("halt_bit", 32'(bit0), 1);
                step(0, 0, 1);
            end
        end
        chk("halt_busy", 32'(busy0), 0);
        chk("halt_nom", 32'(nom0), 6);
        chk("halt_q", 32'(exp_q.size()), 0);
        step(0, 1, 0);
        push_frame(0, 6);
        repeat (6) step(1, 0, 0);
        // parity, LSB first
        do_clr();
        cur = 1;
        step(0, 1, 0);
        push_frame(1, 0);
        push_frame(1, 1);
        repeat (14) step(1, 0, 0);
        chk("par_nom", 32'(nom1), 1);
        // one-shot pass, tick every third cycle
        do_clr();
        cur = 2;
        step(0, 1, 0);
        for (int i = 0; i < 16; i++) push_frame(2, i);
        exp_q.push_back(1'b1);
        for (int i = 1; i <= 97; i++) begin
            step(0, 0, 0);
            step(0, 0, 0);
            step(1, 0, 0);
            if (i == 96) chk("once_done_early", 32'(done2), 0);
        end
        chk("once_done", 32'(done2), 1);
        step(0, 0, 0);
        chk("once_done_pulse", 32'(done2), 0);
        chk("once_done_cnt", 32'(done_cnt), 1);
        chk("once_busy", 32'(busy2), 0);
        chk("once_nom", 32'(nom2), 0);
        step(0, 1, 0);
        push_frame(2, 0);
        repeat (6) step(1, 0, 0);
        chk("once_again_q", 32'(exp_q.size()), 0);
        // asynchronous clr in the middle of word 3
        do_clr();
        cur = 0;
        step(0, 1, 0);
        for (int i = 0; i < 4; i++) push_frame(0, i);
        repeat (21) step(1, 0, 0);
        chk("mid_nom", 32'(nom0), 3);
        #3 clr = 1'b1;
        #1;
        chk("aclr_tx", 32'(tx0), 1);
        chk("aclr_nom", 32'(nom0), 0);
        chk("aclr_busy", 32'(busy0), 0);
        chk("aclr_bit", 32'(bit0), 0);
        @(posedge hit);
        #1;
        clr = 1'b0;
        exp_q.delete();
        last_exp = 1'b1;
        step(0, 1, 0);
        push_frame(0, 0);
        repeat (6) step(1, 0, 0);
        // small table: DEPTH=5, WORD_W=3
        do_clr();
        cur = 3;
        step(0, 1, 0);
        for (int i = 0; i < 5; i++) push_frame(3, i);
        exp_q.push_back(1'b0);
        for (int i = 1; i <= 26; i++) begin
            step(1, 0, 0);
            if (i == 25) chk("small_nom4", 32'(nom3), 4);
        end
        chk("small_done", 32'(done3), 1);
        chk("small_wrap", 32'(nom3), 0);
        chk("small_busy", 32'(busy3), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rom_serializer.md
# rom_serializer

Parametrised ROM-to-serial framer: walks a DEPTH×WORD_W constant table word by word and shifts each word out on TX. Each word is framed as start bit, data, optional parity and stop bit, paced by an external bit-rate tick. It generalises the fixed 16×4 counter/ROM/mux core with configurable width and depth, bit order, parity, one-shot or loop mode, and a start/halt/busy/done handshake. It sits between the front-panel clock domain and the serial output pin.

## Interface
Parameters:
- WORD_W, 4 — data bits per word (2..16)
- DEPTH, 16 — words in table (2..256; need not be a power of 2)
- MSB_FIRST, 1 — 1: data bit WORD_W-1 sent first; 0: bit 0 first
- PARITY_EN, 0 — 1: even-parity bit inserted after data
- LOOP, 1 — 1: restart at word 0 after last word; 0: one pass, then idle

Ports:
- hit  in  1  clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- start  in  1  request a transmission run; one-cycle pulse or level
- halt  in  1  finish current word, then return to IDLE
- tick  in  1  bit-rate enable, one hit cycle wide
- NOM  out  AW=$clog2(DEPTH)  current word address
- BIT  out  BW=$clog2(WORD_W)  current data-bit counter
- LE  out  WORD_W  table word at NOM (combinational)
- TX  out  1  serial line, registered, idle high
- busy  out  1  high from leaving IDLE until return to IDLE
- done  out  1  one-cycle pulse after the last word's stop bit

## Operation
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY_EN=0.
- Reset values: state IDLE, NOM=0, BIT=0, TX=1, busy=0, done=0, pending=0, halt_req=0.
- A start pulse in IDLE sets pending. Start outside IDLE is ignored.
- IDLE→START on tick && pending. pending clears; busy=1; TX=0.
- Every transition except the IDLE entry condition above requires tick=1. Between ticks, state and TX hold.
- START→DATA: BIT=0.
  - TX = LE[WORD_W-1-BIT] if MSB_FIRST, else LE[BIT].
- DATA: BIT increments per tick. At BIT=WORD_W-1 the next tick goes to PARITY (TX=^LE) or to STOP (TX=1). BIT returns to 0.
- STOP→ (on tick):
  - NOM advances: NOM=DEPTH-1 wraps to 0, else NOM+1.
  - If the word just sent was DEPTH-1, done=1 for exactly one hit cycle.
  - Next state is IDLE if halt_req, or if the last word was sent and LOOP=0. busy=0, TX=1, halt_req clears.
  - Otherwise next state is START with TX=0 (back-to-back, no idle bit).
- A halt pulse at any time while busy sets halt_req. halt never truncates a word. halt in IDLE is ignored. A halted run resumes from the current NOM on the next start.
- NOM does not reset to 0 on start. Only clr or the wrap returns it to 0.
- Simultaneous done and halt: done still pulses.
- LE is combinational from the ROM at NOM. LE is stable for a whole frame because NOM changes only on the STOP exit edge.
- Default table contents: word[i] = (DEPTH-1-i) mod 2^WORD_W.

## Timing
- Frame length: 2 + WORD_W + PARITY_EN ticks per word.
- TX, state, NOM, BIT, busy and done all update on the same hit edge. No additional pipeline stage.
- Latency: the first start bit appears on the edge of the first tick after pending is set. A start and tick in the same cycle set pending only, so transmission begins on the next tick.
- done aligns with the edge that ends the final stop bit.
- clr mid-frame: all outputs return to their reset values immediately, without waiting for a clock edge. TX returns high asynchronously.

## Structure
- Shared package `serial_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - TX_IDLE=1'b1, TX_START=1'b0
  - the default-table function
- Sub-module `rom_table`:
  - parameters WORD_W, DEPTH
  - address in, word out
  - combinational
  - contents from the package function
- Bit selection, parity and the FSM stay in `rom_serializer`.

## Test plan
- Defaults, tick every cycle, one start pulse after clr → word 0 = 4'hF: TX 0,1,1,1,1,1. Word 1 = 4'hE: TX 0,1,1,1,0,1. NOM goes 0→1 at the STOP exit edge.
- PARITY_EN=1, MSB_FIRST=0, word 4'hE → TX 0,0,1,1,1,1,1 (LSB first, parity 1, stop); frame is 7 ticks.
- LOOP=0, tick every 3rd cycle → 16 frames (288 cycles). done pulses once, then IDLE with busy=0, TX=1, NOM=0. A second start sends word 0 again.
- halt asserted at DATA BIT=1 of word 5 → word 5 completes, then IDLE with NOM=6. The next start transmits word 6 first.
- clr asserted mid-DATA of word 3, between hit edges → TX=1, NOM=0, busy=0 before the next hit edge. start after clr is accepted normally.
- DEPTH=5, WORD_W=3 → NOM wraps 4→0 and done pulses after word 4. BIT never exceeds 2.
